// File: rtl/mips_pkg.sv
// Shared encodings for the MEM->WB writeback path: result source, load kind, $0 index.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int GPR_AW = 5;
  localparam logic [GPR_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_LINK = 2'd2
  } result_src_t;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4,
    LT_LWL = 3'd5,
    LT_LWR = 3'd6
  } load_type_t;

endpackage

// File: rtl/load_align.sv
// Big-endian load extraction: picks byte/half/word by offset, extends, and merges LWL/LWR with rt.
module load_align
  import mips_pkg::*;
(
  input  logic [2:0]      i_load_type,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_word,
  input  logic [XLEN-1:0] i_rt,
  output logic [XLEN-1:0] o_value
);

  logic [4:0]      w_sh_l;
  logic [4:0]      w_sh_r;
  logic [XLEN-1:0] w_shr;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  // byte k lives at W >> 8*(3-k); 3-k on two bits is just ~k
  assign w_sh_l = {i_offset, 3'b000};
  assign w_sh_r = {~i_offset, 3'b000};
  assign w_shr  = i_word >> w_sh_r;
  assign w_byte = w_shr[7:0];
  assign w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];

  always_comb begin
    o_value = i_word;
    case (load_type_t'(i_load_type))
      LT_LB:   o_value = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_value = {24'h0, w_byte};
      LT_LH:   o_value = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_value = {16'h0, w_half};
      LT_LWL:  o_value = (i_word << w_sh_l) | (i_rt & ((32'd1 << w_sh_l) - 32'd1));
      LT_LWR:  o_value = w_shr | (i_rt & ~(32'hFFFF_FFFF >> w_sh_r));
      default: o_value = i_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and writeback mux driving the register file write port.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dest_reg,
  input  logic [1:0]        mem_result_src,
  input  logic [2:0]        mem_load_type,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] mem_rt_data,
  input  logic [DATA_W-1:0] mem_link_addr,
  output logic              write_en,
  output logic [REG_AW-1:0] address_write,
  output logic [DATA_W-1:0] write_data,
  output logic              wb_valid
);

  logic              r_valid;
  logic              r_reg_write;
  logic [REG_AW-1:0] r_dest;
  logic [1:0]        r_result_src;
  logic [2:0]        r_load_type;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_rd;
  logic [DATA_W-1:0] r_rt;
  logic [DATA_W-1:0] r_link;
  logic [DATA_W-1:0] w_load;

  // flush beats stall so a bubble always lands even while the stage is frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_dest       <= '0;
      r_result_src <= '0;
      r_load_type  <= '0;
      r_alu        <= '0;
      r_rd         <= '0;
      r_rt         <= '0;
      r_link       <= '0;
    end else if (!stall) begin
      r_valid      <= mem_valid;
      r_reg_write  <= mem_reg_write;
      r_dest       <= mem_dest_reg;
      r_result_src <= mem_result_src;
      r_load_type  <= mem_load_type;
      r_alu        <= mem_alu_result;
      r_rd         <= mem_read_data;
      r_rt         <= mem_rt_data;
      r_link       <= mem_link_addr;
    end
  end

  load_align u_load_align (
    .i_load_type (r_load_type),
    .i_offset    (r_alu[1:0]),
    .i_word      (r_rd),
    .i_rt        (r_rt),
    .o_value     (w_load)
  );

  always_comb begin
    write_data = r_alu;
    case (result_src_t'(r_result_src))
      RES_LOAD: write_data = w_load;
      RES_LINK: write_data = r_link;
      default:  write_data = r_alu;
    endcase
  end

  assign write_en      = r_valid & r_reg_write & (r_dest != REG_ZERO);
  assign address_write = r_dest;
  assign wb_valid      = r_valid;

endmodule
